// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: reads up to FETCH_WIDTH words per cycle from a flat
// little-endian byte ROM into a small FIFO that feeds decode over valid/ready.
module fetch_queue_unit #(
  parameter int          ROM_BYTES   = 1024,
  parameter int          FETCH_WIDTH = 2,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ROM_BYTES*8-1:0] instr_rom,
  input  logic [31:0]            rom_size,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_pc,
  output logic [31:0]            fetch_pc,
  output logic                   fetch_complete
);

  localparam int ROM_WORDS = ROM_BYTES / 4;
  localparam int IDX_W     = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
  localparam int PTR_W     = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W     = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MASK     = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [31:0]      ROM_BYTES_32 = 32'(ROM_BYTES);
  localparam logic [CNT_W-1:0] SPACE_LIMIT  = CNT_W'(QUEUE_DEPTH - FETCH_WIDTH);

  // Queue storage and control state
  logic [31:0]      mem_instr_q [QUEUE_DEPTH];
  logic [31:0]      mem_instr_d [QUEUE_DEPTH];
  logic [31:0]      mem_pc_q    [QUEUE_DEPTH];
  logic [31:0]      mem_pc_d    [QUEUE_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             fetch_complete_q, fetch_complete_d;

  logic [31:0]      rom_word   [ROM_WORDS];
  logic [31:0]      lane_addr  [FETCH_WIDTH];
  logic [31:0]      lane_instr [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] lane_ok;
  logic [32:0]      limit;
  logic             space_ok;
  logic             pop;
  logic             enq_run;
  logic [CNT_W-1:0] enq_n;

  generate
    for (genvar gi = 0; gi < ROM_WORDS; gi++) begin : g_rom_word
      assign rom_word[gi] = instr_rom[gi*32 +: 32];
    end
  endgenerate

  assign limit = (rom_size < ROM_BYTES_32) ? {1'b0, rom_size} : {1'b0, ROM_BYTES_32};

  // 33-bit compare so a lane address that wrapped past 2^32 is never fetchable
  generate
    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
      logic [IDX_W-1:0] idx;
      assign lane_addr[gi]  = fetch_pc_q + 32'(4 * gi);
      assign lane_ok[gi]    = ({1'b0, lane_addr[gi]} + 33'd4) <= limit;
      assign idx            = lane_addr[gi][IDX_W+1:2];
      assign lane_instr[gi] = lane_ok[gi] ? rom_word[idx] : 32'h0;
    end
  endgenerate

  assign space_ok = (count_q <= SPACE_LIMIT);
  assign pop      = out_valid && out_ready && !redirect_valid;

  always_comb begin
    enq_run = 1'b1;
    enq_n   = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (enq_run && lane_ok[k]) begin
        enq_n = enq_n + CNT_W'(1);
      end else begin
        enq_run = 1'b0;
      end
    end
    if (redirect_valid || !space_ok) begin
      enq_n = '0;
    end
  end

  always_comb begin
    mem_instr_d      = mem_instr_q;
    mem_pc_d         = mem_pc_q;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    fetch_pc_d       = fetch_pc_q;
    fetch_complete_d = !lane_ok[0] && (count_q == '0) && !redirect_valid;

    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (CNT_W'(k) < enq_n) begin
        mem_instr_d[(tail_q + PTR_W'(k)) & PTR_MASK] = lane_instr[k];
        mem_pc_d[(tail_q + PTR_W'(k)) & PTR_MASK]    = lane_addr[k];
      end
    end
    tail_d     = (tail_q + PTR_W'(enq_n)) & PTR_MASK;
    fetch_pc_d = fetch_pc_q + (32'(enq_n) << 2);
    if (pop) begin
      head_d = (head_q + PTR_W'(1)) & PTR_MASK;
    end
    count_d = count_q + enq_n - CNT_W'(pop);

    // A redirect squashes everything in flight, including a head being accepted
    if (redirect_valid) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc & ~32'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      fetch_pc_q       <= RESET_PC;
      fetch_complete_q <= 1'b0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      fetch_pc_q       <= fetch_pc_d;
      fetch_complete_q <= fetch_complete_d;
    end
  end

  // Payload needs no reset: outputs are masked while the queue is empty
  always_ff @(posedge clk) begin
    mem_instr_q <= mem_instr_d;
    mem_pc_q    <= mem_pc_d;
  end

  assign out_valid      = (count_q != '0);
  assign out_instr      = out_valid ? mem_instr_q[head_q] : 32'h0;
  assign out_pc         = out_valid ? mem_pc_q[head_q] : 32'h0;
  assign fetch_pc       = fetch_pc_q;
  assign fetch_complete = fetch_complete_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: a queue-based reference model predicts
// the instruction stream; a negedge monitor pops and compares accepted heads.
module tb_fetch_queue_unit;

  localparam int          ROM_BYTES   = 64;
  localparam int          FETCH_WIDTH = 2;
  localparam int          QUEUE_DEPTH = 4;
  localparam logic [31:0] RESET_PC    = 32'h0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [ROM_BYTES*8-1:0] instr_rom;
  logic [31:0]            rom_size;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_instr;
  logic [31:0]            out_pc;
  logic [31:0]            fetch_pc;
  logic                   fetch_complete;

  logic [7:0]  rom_b [ROM_BYTES];
  ent_t        exp_q[$];
  logic [31:0] acc_pc[$];
  logic [31:0] acc_instr[$];
  logic [31:0] m_pc;
  bit          m_fc;
  bit          pending_pop;
  bit          just_reset;
  bit          mon_en;
  int          checks;
  int          errors;

  fetch_queue_unit #(
    .ROM_BYTES  (ROM_BYTES),
    .FETCH_WIDTH(FETCH_WIDTH),
    .QUEUE_DEPTH(QUEUE_DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_rom     (instr_rom),
    .rom_size      (rom_size),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fetch_pc      (fetch_pc),
    .fetch_complete(fetch_complete)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] min_limit(input logic [31:0] sz);
    return (sz < 32'(ROM_BYTES)) ? sz : 32'(ROM_BYTES);
  endfunction

  // A word is fetchable when all four of its bytes lie inside the program
  function automatic bit fetchable(input logic [31:0] a, input logic [31:0] lim);
    return ({32'h0, a} + 64'd4) <= {32'h0, lim};
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int i;
    i = int'(a);
    return {rom_b[i+3], rom_b[i+2], rom_b[i+1], rom_b[i]};
  endfunction

  task automatic pack_rom();
    for (int i = 0; i < ROM_BYTES; i++) instr_rom[i*8 +: 8] = rom_b[i];
  endtask

  task automatic load_program();
    logic [31:0] w;
    for (int i = 0; i < ROM_BYTES; i++) rom_b[i] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 4; k++) begin
      w = 32'(8'h11 * (k + 1));
      for (int b = 0; b < 4; b++) rom_b[4*k+b] = w[8*b +: 8];
    end
    pack_rom();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic clear_log();
    acc_pc.delete();
    acc_instr.delete();
  endtask

  // Reference model: advances on each rising edge from the inputs being sampled
  initial begin
    logic [31:0] lim;
    logic [31:0] a;
    int          occ;
    int          n;
    forever begin
      @(posedge clk);
      if (reset) begin
        exp_q.delete();
        m_pc       = RESET_PC;
        m_fc       = 1'b0;
        just_reset = 1'b1;
        mon_en     = 1'b1;
      end else begin
        occ  = exp_q.size() + (pending_pop ? 1 : 0);
        lim  = min_limit(rom_size);
        m_fc = !fetchable(m_pc, lim) && (occ == 0) && !redirect_valid;
        if (redirect_valid) begin
          exp_q.delete();
          m_pc = redirect_pc & ~32'd3;
        end else if (QUEUE_DEPTH - occ >= FETCH_WIDTH) begin
          n = 0;
          for (int k = 0; k < FETCH_WIDTH; k++) begin
            a = m_pc + 32'(4 * k);
            if (!fetchable(a, lim)) break;
            exp_q.push_back('{pc: a, instr: model_word(a)});
            n++;
          end
          m_pc = m_pc + 32'(4 * n);
        end
        just_reset = 1'b0;
      end
      pending_pop = 1'b0;
    end
  end

  // Monitor: compares DUT outputs mid-cycle, pops the head that the next edge accepts
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("fetch_pc", fetch_pc, m_pc);
        check("fetch_complete", 32'(fetch_complete), 32'(m_fc));
        if (just_reset) begin
          check("reset_out_instr", out_instr, 32'h0);
          check("reset_out_pc", out_pc, 32'h0);
        end
        if (out_valid && exp_q.size() > 0) begin
          e = exp_q[0];
          check("out_pc", out_pc, e.pc);
          check("out_instr", out_instr, e.instr);
          if (out_ready && !redirect_valid && !reset) begin
            void'(exp_q.pop_front());
            pending_pop = 1'b1;
            acc_pc.push_back(out_pc);
            acc_instr.push_back(out_instr);
            $display("accept pc=%h instr=%h", out_pc, out_instr);
          end
        end
      end
    end
  end

  initial begin
    bit done;
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    pending_pop = 1'b0;
    just_reset = 1'b0;
    m_pc = RESET_PC;
    m_fc = 1'b0;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    rom_size = 32'd16;
    load_program();

    // Straight-line run of a four-word program
    out_ready = 1'b1;
    do_reset();
    clear_log();
    step(10);
    check("run_count", 32'(acc_instr.size()), 32'd4);
    for (int k = 0; k < 4 && k < acc_instr.size(); k++) begin
      check("run_instr", acc_instr[k], 32'(8'h11 * (k + 1)));
      check("run_pc", acc_pc[k], 32'(4 * k));
    end
    check("run_complete", 32'(fetch_complete), 32'd1);

    // Back-pressure: queue fills, head holds, then drains in order
    out_ready = 1'b0;
    do_reset();
    clear_log();
    step(10);
    check("bp_fetch_pc", fetch_pc, 32'd16);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_head_instr", out_instr, 32'h11);
    check("bp_head_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    step(10);
    check("bp_drain_count", 32'(acc_instr.size()), 32'd4);
    for (int k = 0; k < 4 && k < acc_instr.size(); k++)
      check("bp_drain_instr", acc_instr[k], 32'(8'h11 * (k + 1)));

    // Short program: second fetch is a single word
    rom_size = 32'd12;
    do_reset();
    clear_log();
    step(10);
    check("short_count", 32'(acc_pc.size()), 32'd3);
    for (int k = 0; k < 3 && k < acc_pc.size(); k++) check("short_pc", acc_pc[k], 32'(4 * k));

    // Redirect with three queued entries and decode ready
    out_ready = 1'b0;
    do_reset();
    clear_log();
    step(2);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000000A;
    step(1);
    redirect_valid = 1'b0;
    check("redir_valid", 32'(out_valid), 32'd0);
    check("redir_no_pop", 32'(acc_pc.size()), 32'd0);
    step(6);
    check("redir_count", 32'(acc_pc.size()), 32'd1);
    if (acc_pc.size() > 0) begin
      check("redir_pc", acc_pc[0], 32'd8);
      check("redir_instr", acc_instr[0], 32'h33);
    end

    // Redirect out of the completed state replays the program
    rom_size = 32'd16;
    do_reset();
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      step(1);
      if (fetch_complete) done = 1'b1;
    end
    check("complete_reached", 32'(done), 32'd1);
    clear_log();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step(1);
    redirect_valid = 1'b0;
    check("replay_complete_low", 32'(fetch_complete), 32'd0);
    step(10);
    check("replay_count", 32'(acc_instr.size()), 32'd4);
    if (acc_instr.size() > 0) check("replay_first", acc_instr[0], 32'h11);

    // Reset with a full queue
    out_ready = 1'b0;
    do_reset();
    step(4);
    reset = 1'b1;
    step(1);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_pc", fetch_pc, RESET_PC);
    reset = 1'b0;
    out_ready = 1'b1;
    clear_log();
    step(10);
    check("midrst_count", 32'(acc_instr.size()), 32'd4);
    if (acc_instr.size() > 0) check("midrst_first", acc_instr[0], 32'h11);

    // Randomised traffic: back-pressure, redirects, resets, program length changes
    for (int i = 0; i < ROM_BYTES; i++) rom_b[i] = 8'($urandom_range(0, 255));
    pack_rom();
    rom_size = 32'(ROM_BYTES);
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 4))
        0: redirect_pc = 32'hFFFFFFF8;
        1: redirect_pc = 32'hFFFFFFFC;
        2: redirect_pc = $urandom;
        default: redirect_pc = 32'($urandom_range(0, ROM_BYTES + 8));
      endcase
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 5))
          0: rom_size = 32'd0;
          1: rom_size = 32'd3;
          2: rom_size = 32'd4;
          3: rom_size = 32'hFFFFFFFF;
          default: rom_size = 32'($urandom_range(0, ROM_BYTES + 16));
        endcase
      end
      step(1);
    end
    reset = 1'b0;
    redirect_valid = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised next-generation instruction fetch stage. It holds its own PC and reads up to FETCH_WIDTH consecutive 32-bit instructions per cycle from the flat little-endian byte ROM into a FIFO of QUEUE_DEPTH entries. The FIFO presents one instruction per cycle to decode over a valid/ready handshake. Supports branch redirect with flush and a clean end-of-program indication; sits between the instruction ROM and decode.

Parameters:
ROM_BYTES, 1024, byte capacity of instr_rom (multiple of 4)
FETCH_WIDTH, 2, max instructions enqueued per cycle (1..4)
QUEUE_DEPTH, 4, FIFO entries (power of 2, >= FETCH_WIDTH)
RESET_PC, 0, PC loaded on reset (word aligned)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
instr_rom  in  ROM_BYTES*8  instruction memory; byte b at bits [8b+7:8b]
rom_size  in  32  valid program length in bytes
redirect_valid  in  1  load new PC and flush this cycle
redirect_pc  in  32  target PC; bits [1:0] ignored (forced 0)
out_valid  out  1  queue head holds an instruction
out_ready  in  1  decode accepts head this cycle
out_instr  out  32  head instruction
out_pc  out  32  PC of head instruction
fetch_pc  out  32  current fetch PC register
fetch_complete  out  1  program end reached and queue drained

Behaviour:
- Reset (sync, priority over all): fetch_pc=RESET_PC, queue empty, out_valid=0, out_instr=0, out_pc=0, fetch_complete=0.
- limit = min(rom_size, ROM_BYTES). Instruction at address a is fetchable iff a+4 <= limit (a full word lies inside the program; the last word is fetchable).
- Enqueue count n each cycle: n = number of consecutive fetchable words from fetch_pc, capped at FETCH_WIDTH; n=0 if free slots < FETCH_WIDTH (all-or-nothing on space, free counted before this cycle's dequeue) or redirect_valid=1. Entry k gets instr_rom[(fetch_pc+4k)*8 +: 32] and pc fetch_pc+4k. fetch_pc += 4n.
- Dequeue: when out_valid && out_ready, head pops. Enqueue and dequeue in the same cycle are both honoured; occupancy += n - pop.
- out_valid/out_instr/out_pc reflect the registered queue head only (no combinational path from instr_rom or redirect to the outputs). First-fetch latency: first word visible on out_valid one cycle after reset deasserts.
- Redirect: at the edge with redirect_valid=1, the queue is emptied (count=0, pointers reset), fetch_pc=redirect_pc&~3, and any concurrent dequeue is discarded (head treated as squashed). out_valid=0 in the following cycle; new-target instructions appear one cycle later. Redirect overrides the space check.
- fetch_complete: registered; 1 when no word is fetchable at fetch_pc AND the queue is empty AND redirect_valid=0; otherwise 0. A redirect to a fetchable address clears it next cycle.
- out_valid held with out_ready=0: head stable (instr, pc unchanged) until accepted or flushed.
- Full queue: no enqueue, fetch_pc holds. Pointers wrap modulo QUEUE_DEPTH.
- Address arithmetic is 32-bit unsigned; fetch_pc+4k is computed without overflow checks; a wrapped address is non-fetchable because it fails a+4 <= limit.
- rom_size=0 or rom_size<4: nothing fetchable; fetch_complete=1 one cycle after reset.

Test Plan:
- Reset, rom_size=16, words 0x11,0x22,0x33,0x44, out_ready=1 -> out_instr 0x11,0x22,0x33,0x44 with out_pc 0,4,8,12 on consecutive valid cycles; fetch_complete=1 after the last is accepted; the last word is fetched.
- out_ready=0 for 10 cycles, FETCH_WIDTH=2, QUEUE_DEPTH=4 -> queue fills to 4, fetch_pc stops at 16, head stays 0x11/pc 0; release -> in-order drain, no loss or duplication.
- rom_size=12, FETCH_WIDTH=2 -> second fetch enqueues a single word (pc 8); no word at pc 12 appears.
- Redirect to 0x0000000A while the queue holds 3 entries and out_ready=1 -> no entry pops; out_valid=0 next cycle; the following head has out_pc=8.
- Redirect while fetch_complete=1 to pc 0 -> fetch_complete drops and the program replays from 0x11.
- Assert reset mid-stream with a full queue -> next cycle out_valid=0, fetch_pc=RESET_PC, and refetch restarts cleanly.
